// File: rtl/rs_pkg.sv
// Shared reservation-station constants: tag/wakeup widths and the opaque payload layout.
package rs_pkg;

    localparam int RS_TAG_W     = 8;
    localparam int RS_NUM_WB    = 7;
    localparam int RS_PAYLOAD_W = 107;

    // Payload field offsets, LSB first.
    localparam int PL_IMM_LSB     = 0;
    localparam int PL_IMM_W       = 32;
    localparam int PL_PC_LSB      = 32;
    localparam int PL_PC_W        = 32;
    localparam int PL_INST_LSB    = 64;
    localparam int PL_INST_W      = 32;
    localparam int PL_RD_LSB      = 96;
    localparam int PL_RD_W        = 5;
    localparam int PL_ALUOP_LSB   = 101;
    localparam int PL_ALUOP_W     = 4;
    localparam int PL_ALUSRC1_LSB = 105;
    localparam int PL_ALUSRC2_LSB = 106;

    typedef struct packed {
        logic                  alu_src2;
        logic                  alu_src1;
        logic [PL_ALUOP_W-1:0] alu_op;
        logic [PL_RD_W-1:0]    rd;
        logic [PL_INST_W-1:0]  inst_num;
        logic [PL_PC_W-1:0]    pc;
        logic [PL_IMM_W-1:0]   imm;
    } rs_payload_t;

    // Wakeup channel order on the broadcast bus.
    typedef enum int {
        WB_ALU = 0, WB_MUL = 1, WB_DIV = 2, WB_MEM = 3, WB_BR = 4, WB_P = 5, WB_CSR = 6
    } wb_chan_e;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the issue queue: older_q[i][j] is set when entry i was dispatched before entry j.
module rs_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] vld,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    // A new entry is younger than every live entry and older than none.
    always_comb begin
        older_d = older_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (alloc_oh[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    older_d[k][i] = 1'b0;
                    older_d[i][k] = vld[i];
                end
            end
        end
        if (flush) older_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) older_q <= '0;
        else        older_q <= older_d;
    end

    always_comb begin
        grant = req;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (req[j] && older_q[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: wakeup/select reservation station with age-ordered pick and one registered issue slot.
module alu_issue_queue
    import rs_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TAG_W     = RS_TAG_W,
    parameter int NUM_WB    = RS_NUM_WB,
    parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    input  logic [TAG_W-1:0]             disp_tag1,
    input  logic [TAG_W-1:0]             disp_tag2,
    input  logic [1:0]                   disp_rdy,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [2*TAG_W+PAYLOAD_W-1:0] iss_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DW    = 2*TAG_W + PAYLOAD_W;

    function automatic logic tag_hit(input logic [NUM_WB-1:0]       v,
                                     input logic [NUM_WB*TAG_W-1:0] tags,
                                     input logic [TAG_W-1:0]        t);
        logic h;
        h = 1'b0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (v[c] && tags[c*TAG_W +: TAG_W] == t) h = 1'b1;
        end
        return h;
    endfunction

    logic [DEPTH-1:0]                vld_q, vld_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [DEPTH-1:0][TAG_W-1:0]     tag1_q, tag2_q;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] pay_q;
    logic [CNT_W-1:0]                count_q, count_d;
    logic                            iss_valid_q, iss_valid_d;
    logic [DW-1:0]                   iss_data_q, iss_data_d;

    logic [DEPTH-1:0]     alloc_oh, alloc_fire, req, grant;
    logic                 disp_fire, sel_any, slot_load;
    logic                 disp_hit1, disp_hit2;
    logic [TAG_W-1:0]     sel_t1, sel_t2;
    logic [PAYLOAD_W-1:0] sel_pay;

    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    // Lowest clear bit of the valid vector.
    assign alloc_oh   = ~vld_q & (vld_q + DEPTH'(1));
    assign alloc_fire = alloc_oh & {DEPTH{disp_fire}};
    assign disp_hit1  = tag_hit(wb_valid, wb_tag, disp_tag1);
    assign disp_hit2  = tag_hit(wb_valid, wb_tag, disp_tag2);

    assign req       = vld_q & rdy1_q & rdy2_q;
    assign sel_any   = |req;
    assign slot_load = sel_any && (!iss_valid_q || iss_ready);

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk      (clk),
        .rst_n    (reset_n),
        .flush    (flush),
        .alloc_oh (alloc_fire),
        .vld      (vld_q),
        .req      (req),
        .grant    (grant)
    );

    always_comb begin
        sel_t1  = '0;
        sel_t2  = '0;
        sel_pay = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_t1  = sel_t1  | ({TAG_W{grant[i]}}     & tag1_q[i]);
            sel_t2  = sel_t2  | ({TAG_W{grant[i]}}     & tag2_q[i]);
            sel_pay = sel_pay | ({PAYLOAD_W{grant[i]}} & pay_q[i]);
        end
    end

    always_comb begin
        vld_d  = vld_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_hit(wb_valid, wb_tag, tag1_q[i])) rdy1_d[i] = 1'b1;
            if (tag_hit(wb_valid, wb_tag, tag2_q[i])) rdy2_d[i] = 1'b1;
            if (slot_load && grant[i]) vld_d[i] = 1'b0;
            if (alloc_fire[i]) begin
                vld_d[i]  = 1'b1;
                rdy1_d[i] = disp_rdy[0] | disp_hit1;
                rdy2_d[i] = disp_rdy[1] | disp_hit2;
            end
        end
        if (flush) begin
            vld_d  = '0;
            rdy1_d = '0;
            rdy2_d = '0;
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_data_d  = iss_data_q;
        count_d     = count_q + CNT_W'(disp_fire) - CNT_W'(slot_load);
        if (slot_load) begin
            iss_valid_d = 1'b1;
            iss_data_d  = {sel_t2, sel_t1, sel_pay};
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
        if (flush) begin
            iss_valid_d = 1'b0;
            iss_data_d  = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q       <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_data_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_data_q  <= iss_data_d;
        end
    end

    // Tags and payload are only meaningful under vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire[i]) begin
                tag1_q[i] <= disp_tag1;
                tag2_q[i] <= disp_tag2;
                pay_q[i]  <= disp_payload;
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_data  = iss_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed vector table, hand sequences and random traffic vs a queue-based model.
module tb_alu_issue_queue;

    localparam int DEPTH = 16, TAG_W = 8, NUM_WB = 7, PW = 107;
    localparam int DW = 2*TAG_W + PW;

    logic                    clk = 1'b0;
    logic                    reset_n, flush, disp_valid, disp_ready, iss_valid, iss_ready;
    logic [PW-1:0]           disp_payload;
    logic [TAG_W-1:0]        disp_tag1, disp_tag2;
    logic [1:0]              disp_rdy;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [DW-1:0]           iss_data;
    logic [$clog2(DEPTH):0]  count;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_rdy(disp_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: entries kept in dispatch order, so the first ready one is the oldest.
    typedef struct {
        logic [TAG_W-1:0] t1, t2;
        logic             r1, r2;
        logic [PW-1:0]    pl;
    } ment_t;
    ment_t         mq[$];
    logic          m_iv = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] issued[$];

    typedef struct {
        logic dv; logic [7:0] t1, t2; logic [1:0] rdy; int wch; logic [7:0] wtag;
        logic ir; logic eiv; int ecnt; logic [7:0] et1, et2;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(int dv, int t1, int t2, int rdy, int wch, int wtag,
                                int ir, int eiv, int ecnt, int et1, int et2);
        vec_t v;
        v.dv = dv[0]; v.t1 = t1[7:0]; v.t2 = t2[7:0]; v.rdy = rdy[1:0];
        v.wch = wch; v.wtag = wtag[7:0]; v.ir = ir[0]; v.eiv = eiv[0];
        v.ecnt = ecnt; v.et1 = et1[7:0]; v.et2 = et2[7:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [TAG_W-1:0] t);
        for (int c = 0; c < NUM_WB; c++)
            if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_iv = 1'b0;
        m_data = '0;
    endtask

    task automatic model_edge();
        int n, s;
        ment_t e;
        n = mq.size();
        if (!reset_n || flush) begin
            model_clear();
            return;
        end
        if (!m_iv || iss_ready) begin
            s = -1;
            for (int k = 0; k < mq.size(); k++)
                if (s < 0 && mq[k].r1 && mq[k].r2) s = k;
            if (s >= 0) begin
                m_iv = 1'b1;
                m_data = {mq[s].t2, mq[s].t1, mq[s].pl};
                mq.delete(s);
            end else begin
                m_iv = 1'b0;
            end
        end
        for (int k = 0; k < mq.size(); k++) begin
            if (hit(mq[k].t1)) mq[k].r1 = 1'b1;
            if (hit(mq[k].t2)) mq[k].r2 = 1'b1;
        end
        if (disp_valid && n < DEPTH) begin
            e.t1 = disp_tag1; e.t2 = disp_tag2; e.pl = disp_payload;
            e.r1 = disp_rdy[0] || hit(disp_tag1);
            e.r2 = disp_rdy[1] || hit(disp_tag2);
            mq.push_back(e);
        end
    endtask

    task automatic compare_model();
        chk("m_iss_valid", iss_valid, m_iv);
        chk("m_count", count, mq.size());
        chk("m_disp_ready", disp_ready, mq.size() < DEPTH);
        if (m_iv) chk("m_iss_data", iss_data, m_data);
    endtask

    task automatic step();
        if (iss_valid && iss_ready && !flush && reset_n) issued.push_back(iss_data);
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle();
        disp_valid = 1'b0; wb_valid = '0; flush = 1'b0; disp_rdy = '0;
    endtask

    task automatic disp(input int t1, input int t2, input int rdy, input int pl);
        disp_valid = 1'b1; disp_tag1 = t1[7:0]; disp_tag2 = t2[7:0];
        disp_rdy = rdy[1:0]; disp_payload = PW'(pl);
        step();
        disp_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] cap;
        reset_n = 1'b0; iss_ready = 1'b1; disp_tag1 = '0; disp_tag2 = '0;
        disp_payload = '0; wb_tag = '0;
        idle();
        #12;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_iss_data", iss_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_disp_ready", disp_ready, 1);

        // Directed vector table: expected values after the edge of each row.
        vt.push_back(mk(1, 5, 6, 0, -1, 0, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  0, 5, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  1, 6, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 1, 0, 5, 6));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 9, 3, 2,  2, 9, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 1, 0, 9, 3));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 7, 7, 0,  3, 8, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0,  6, 7, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 1, 0, 7, 7));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 2, 3, -1, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 0, 1, 0, 1, 2));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 0, 1, 0, 1, 2));
        vt.push_back(mk(0, 0, 0, 0, -1, 0, 1, 0, 0, 0, 0));
        foreach (vt[k]) begin
            disp_valid = vt[k].dv; disp_tag1 = vt[k].t1; disp_tag2 = vt[k].t2;
            disp_rdy = vt[k].rdy; disp_payload = PW'(k + 1000); iss_ready = vt[k].ir;
            wb_valid = '0;
            if (vt[k].wch >= 0) begin
                wb_valid[vt[k].wch] = 1'b1;
                wb_tag[vt[k].wch*TAG_W +: TAG_W] = vt[k].wtag;
            end
            step();
            chk($sformatf("vec%0d_iv", k), iss_valid, vt[k].eiv);
            chk($sformatf("vec%0d_cnt", k), count, vt[k].ecnt);
            if (vt[k].eiv) begin
                chk($sformatf("vec%0d_tag2", k), iss_data[DW-1 -: TAG_W], vt[k].et2);
                chk($sformatf("vec%0d_tag1", k), iss_data[DW-TAG_W-1 -: TAG_W], vt[k].et1);
            end
        end
        idle();

        // Age beats index: D lands in a lower entry than A but is younger.
        iss_ready = 1'b1;
        issued.delete();
        disp(30, 31, 3, 1);
        disp(20, 21, 0, 2);
        disp(32, 33, 3, 3);
        disp(34, 35, 3, 4);
        disp(20, 21, 0, 5);
        wb_valid = 7'b0000011;
        wb_tag[0 +: TAG_W] = 8'd20;
        wb_tag[TAG_W +: TAG_W] = 8'd21;
        step();
        idle();
        for (int k = 0; k < 5; k++) step();
        chk("age_issue_cnt", issued.size(), 5);
        begin
            int exp_pl[5] = '{1, 3, 4, 2, 5};
            for (int k = 0; k < issued.size() && k < 5; k++)
                chk($sformatf("age_order%0d", k), issued[k][PW-1:0], PW'(exp_pl[k]));
        end

        // Fill to capacity under backpressure, then one issue frees one entry.
        do_flush();
        iss_ready = 1'b0;
        for (int k = 0; k < 17; k++) disp(k + 40, k + 60, 3, k + 200);
        chk("full_count", count, 16);
        chk("full_disp_ready", disp_ready, 0);
        disp_valid = 1'b1; iss_ready = 1'b1;
        step();
        disp_valid = 1'b0; iss_ready = 1'b0;
        chk("full_after_count", count, 15);
        chk("full_after_ready", disp_ready, 1);
        iss_ready = 1'b1;
        for (int k = 0; k < 18; k++) step();

        // Sustained backpressure holds the slot, then three back-to-back issues.
        iss_ready = 1'b0;
        disp(90, 91, 3, 100);
        disp(92, 93, 3, 101);
        disp(94, 95, 3, 102);
        step();
        cap = iss_data;
        chk("hold_first", cap[PW-1:0], PW'(100));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_data", iss_data, cap);
            chk("hold_valid", iss_valid, 1);
        end
        issued.delete();
        iss_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("bp_issue_cnt", issued.size(), 3);
        for (int k = 0; k < issued.size() && k < 3; k++)
            chk($sformatf("bp_order%0d", k), issued[k][PW-1:0], PW'(100 + k));
        step();
        chk("bp_drained", iss_valid, 0);

        // Flush with a full slot, then async reset while a result is presented.
        iss_ready = 1'b0;
        for (int k = 0; k < 9; k++) disp(k + 100, k + 120, 3, k + 300);
        chk("pre_flush_iv", iss_valid, 1);
        chk("pre_flush_cnt", count, 8);
        do_flush();
        chk("flush_iv", iss_valid, 0);
        chk("flush_cnt", count, 0);
        iss_ready = 1'b1;
        disp(1, 2, 3, 400);
        disp(3, 4, 3, 401);
        chk("pre_rst_iv", iss_valid, 1);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_iv", iss_valid, 0);
        chk("async_rst_cnt", count, 0);
        chk("async_rst_data", iss_data, 0);
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", disp_ready, 1);

        // Random traffic: small tag space so wakeups and bypasses are frequent.
        for (int k = 0; k < 3000; k++) begin
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_tag1 = 8'($urandom_range(0, 15));
            disp_tag2 = 8'($urandom_range(0, 15));
            disp_rdy = 2'($urandom_range(0, 3));
            disp_payload = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < NUM_WB; c++) begin
                wb_valid[c] = ($urandom_range(0, 3) == 0);
                wb_tag[c*TAG_W +: TAG_W] = 8'($urandom_range(0, 15));
            end
            iss_ready = (k < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of 2, 4..64).
REQ-002 SHALL have parameter TAG_W, default 8, physical-register tag width.
REQ-003 SHALL have parameter NUM_WB, default 7, number of wakeup broadcast channels.
REQ-004 SHALL have parameter PAYLOAD_W, default 107, opaque per-entry payload width (inst_num, PC, Rd, ALUOP, ALUSrc1/2, immediate).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  exception/mret squash, synchronous.
REQ-008 SHALL have port disp_valid  input  1  dispatch request.
REQ-009 SHALL have port disp_ready  output  1  entry free, dispatch accepted when both high.
REQ-010 SHALL have port disp_payload  input  PAYLOAD_W  dispatched instruction fields.
REQ-011 SHALL have ports disp_tag1/disp_tag2  input  TAG_W each  source tags.
REQ-012 SHALL have port disp_rdy  input  2  source ready bits from rename ([0]=src1, [1]=src2).
REQ-013 SHALL have ports wb_valid  input  NUM_WB  and wb_tag  input  NUM_WB*TAG_W  broadcast completions (ALU, MUL, DIV, MEM, BR, P, CSR).
REQ-014 SHALL have ports iss_valid  output  1, iss_ready  input  1  issue handshake.
REQ-015 SHALL have port iss_data  output  2*TAG_W+PAYLOAD_W  {tag2, tag1, payload}.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL accept dispatch into lowest-index free entry when disp_valid && disp_ready.
REQ-018 SHALL drive disp_ready = (count < DEPTH) from registered state; an entry freed this cycle is reusable next cycle only.
REQ-019 SHALL mark a source ready at dispatch if disp_rdy bit set or its tag matches any valid wb channel that cycle (same-cycle bypass).
REQ-020 SHALL set a stored entry's source ready bit at the edge after any valid wb_tag equals its tag; multiple matching channels are equivalent to one.
REQ-021 SHALL track age per entry; selection SHALL pick the oldest entry with both sources ready (dispatch order, not index).
REQ-022 SHALL hold one registered output slot; when slot empty or iss_ready high, selected entry SHALL be loaded into slot and freed at the same edge.
REQ-023 SHALL hold iss_data stable and iss_valid high while iss_valid && !iss_ready.
REQ-024 SHALL deassert iss_valid at the edge consuming the slot if no entry is ready.
REQ-025 SHALL give minimum latency: dispatch with both sources ready in cycle t -> iss_valid in cycle t+2; wakeup in cycle t -> iss_valid in cycle t+2.
REQ-026 SHALL update count with simultaneous dispatch and issue as +1-1 = unchanged.
REQ-027 SHALL on flush clear all entries, ages, output slot and count at the edge; dispatch and wakeups in the flush cycle are dropped.
REQ-028 SHALL never issue an entry twice nor lose a ready entry under sustained backpressure.

Reset
REQ-029 SHALL on reset_n low asynchronously clear all entry valid/ready bits and age state, iss_valid=0, iss_data=0, count=0, disp_ready=1 after release.

Structure
REQ-030 SHALL place TAG_W, NUM_WB and the payload field layout/offsets in the shared rs package.
REQ-031 SHALL implement age ordering in one sub-module rs_age_matrix (DEPTH x DEPTH bit matrix, set on allocate, oldest-ready one-hot out).

Verification
REQ-032 Dispatch tag1=5,tag2=6, disp_rdy=00; wb ALU tag 5 at t+3, MUL tag 6 at t+5 -> iss_valid at t+7, iss_data tags {6,5}.
REQ-033 Dispatch A (not ready) into entry 0, B, C ready; free entry 0 region, dispatch D; wake A -> issue order B, C, then A before younger D when both ready.
REQ-034 Fill 16 entries -> disp_ready=0, count=16; one issue with iss_ready=1 -> disp_ready=1 next cycle, count=15.
REQ-035 Hold iss_ready=0 for 10 cycles with 3 ready entries -> iss_data constant, then 3 issues on consecutive cycles, no duplicates.
REQ-036 Dispatch with tag1=9 while wb DIV tag 9 valid same cycle -> src1 ready, issue at t+2.
REQ-037 Flush with 8 entries and iss_valid=1 -> next cycle iss_valid=0, count=0; reset_n low mid-issue -> outputs cleared immediately.
